// File: rtl/split_mem_coherent.sv
// Split instruction/data memory with a dirty-address log; a copy engine pushes logged
// DM words into IM on fence.i or when the log fills, keeping instruction fetch coherent.
module split_mem_coherent #(
    parameter  int ADDR_W    = 14,
    parameter  int DATA_W    = 32,
    parameter  int LOG_DEPTH = 256,
    localparam int LOG_AW    = $clog2(LOG_DEPTH)
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_im_ren,
    input  logic [ADDR_W-1:0]   i_im_addr,
    output logic [DATA_W-1:0]   o_im_rdata,
    input  logic                i_dm_ren,
    input  logic                i_dm_wen,
    input  logic [DATA_W/8-1:0] i_dm_ben,
    input  logic [ADDR_W-1:0]   i_dm_addr,
    input  logic [DATA_W-1:0]   i_dm_wdata,
    output logic [DATA_W-1:0]   o_dm_rdata,
    input  logic                i_fence_i,
    output logic                o_ready,
    output logic                o_syncing,
    output logic                o_sync_done,
    output logic [LOG_AW:0]     o_log_count
);

    localparam int              NB       = DATA_W / 8;
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [LOG_AW:0] LOG_FULL = (LOG_AW + 1)'(LOG_DEPTH);
    localparam logic [LOG_AW:0] ONE      = (LOG_AW + 1)'(1);
    localparam logic [LOG_AW:0] ZERO     = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [LOG_AW:0]     r_count;
    logic [LOG_AW:0]     r_head;
    logic [LOG_AW:0]     w_count_after;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [ADDR_W-1:0]   r_log [LOG_DEPTH];
    logic [ADDR_W-1:0]   w_log_rd;
    logic                r_cp_valid;
    logic [ADDR_W-1:0]   r_cp_addr;

    logic                w_ready;
    logic                w_dm_wr;
    logic                w_dup;
    logic                w_append;
    logic                w_sync_rd;
    logic                w_dm_re;
    logic                w_im_re;
    logic [ADDR_W-1:0]   w_dm_raddr;
    logic [DATA_W-1:0]   w_dm_q;

    logic                r_dm_user;
    logic [DATA_W-1:0]   r_dm_hold;
    logic [DATA_W-1:0]   r_im_mem [DEPTH];
    logic [DATA_W-1:0]   r_im_q;

    assign w_ready       = (r_state == S_IDLE) && (r_count < LOG_FULL);
    assign w_dm_wr       = w_ready && i_dm_wen;
    assign w_dup         = (r_count != ZERO) && (i_dm_addr == r_last_addr);
    assign w_append      = w_dm_wr && !w_dup;
    assign w_count_after = w_append ? (r_count + ONE) : r_count;
    assign w_log_rd      = r_log[r_head[LOG_AW-1:0]];

    // The copy engine owns the DM read port while syncing; user requests are blocked then anyway.
    assign w_sync_rd  = (r_state == S_SYNC);
    assign w_dm_re    = w_sync_rd || (w_ready && i_dm_ren);
    assign w_dm_raddr = w_sync_rd ? w_log_rd : i_dm_addr;
    assign w_im_re    = w_ready && i_im_ren;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_fence_i || (w_count_after == LOG_FULL)) begin
                    w_state_next = (w_count_after == ZERO) ? S_DONE : S_SYNC;
                end
            end
            S_SYNC: begin
                if (r_head == (r_count - ONE)) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_head      <= '0;
            r_last_addr <= '0;
            r_cp_valid  <= 1'b0;
            r_cp_addr   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cp_valid <= w_sync_rd;
            r_cp_addr  <= w_log_rd;
            case (r_state)
                S_IDLE: begin
                    if (w_append) begin
                        r_count     <= r_count + ONE;
                        r_last_addr <= i_dm_addr;
                    end
                end
                S_SYNC: r_head <= r_head + ONE;
                S_DONE: begin
                    r_count <= '0;
                    r_head  <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_append) begin
            r_log[r_count[LOG_AW-1:0]] <= i_dm_addr;
        end
    end

    // One byte-wide RAM per lane so byte enables map onto plain single-write arrays.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_dm_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_q;
            always_ff @(posedge clk) begin
                if (w_dm_wr && i_dm_ben[gi]) begin
                    r_mem[i_dm_addr] <= i_dm_wdata[8*gi +: 8];
                end
                if (w_dm_re) begin
                    r_q <= r_mem[w_dm_raddr];
                end
            end
            assign w_dm_q[8*gi +: 8] = r_q;
        end
    endgenerate

    // Engine reads clobber the RAM output register, so the last user word is kept aside.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_dm_user <= 1'b0;
            r_dm_hold <= '0;
        end else begin
            r_dm_user <= w_ready && i_dm_ren;
            if (r_dm_user) begin
                r_dm_hold <= w_dm_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_cp_valid) begin
            r_im_mem[r_cp_addr] <= w_dm_q;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_im_q <= '0;
        end else if (w_im_re) begin
            r_im_q <= r_im_mem[i_im_addr];
        end
    end

    assign o_im_rdata  = r_im_q;
    assign o_dm_rdata  = r_dm_user ? w_dm_q : r_dm_hold;
    assign o_ready     = w_ready;
    assign o_syncing   = (r_state != S_IDLE);
    assign o_sync_done = (r_state == S_DONE);
    assign o_log_count = r_count;

endmodule

// File: tb/tb_split_mem_coherent.sv
// Scoreboard bench for split_mem_coherent: stimulus pushes expected read data and
// sync-done cycles into queues; a negedge monitor pops and compares them.
module tb_split_mem_coherent;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 32;
    localparam int LOG_DEPTH = 4;
    localparam int LOG_AW    = $clog2(LOG_DEPTH);

    logic                clk = 1'b0;
    logic                i_rst;
    logic                i_im_ren;
    logic [ADDR_W-1:0]   i_im_addr;
    logic [DATA_W-1:0]   o_im_rdata;
    logic                i_dm_ren;
    logic                i_dm_wen;
    logic [DATA_W/8-1:0] i_dm_ben;
    logic [ADDR_W-1:0]   i_dm_addr;
    logic [DATA_W-1:0]   i_dm_wdata;
    logic [DATA_W-1:0]   o_dm_rdata;
    logic                i_fence_i;
    logic                o_ready;
    logic                o_syncing;
    logic                o_sync_done;
    logic [LOG_AW:0]     o_log_count;

    split_mem_coherent #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LOG_DEPTH(LOG_DEPTH)
    ) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_im_ren   (i_im_ren),
        .i_im_addr  (i_im_addr),
        .o_im_rdata (o_im_rdata),
        .i_dm_ren   (i_dm_ren),
        .i_dm_wen   (i_dm_wen),
        .i_dm_ben   (i_dm_ben),
        .i_dm_addr  (i_dm_addr),
        .i_dm_wdata (i_dm_wdata),
        .o_dm_rdata (o_dm_rdata),
        .i_fence_i  (i_fence_i),
        .o_ready    (o_ready),
        .o_syncing  (o_syncing),
        .o_sync_done(o_sync_done),
        .o_log_count(o_log_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DATA_W-1:0] q_im [$];
    logic [DATA_W-1:0] q_dm [$];
    int                q_done [$];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: a read accepted at a posedge is compared at the following negedge.
    bit pend_im = 1'b0;
    bit pend_dm = 1'b0;
    always @(negedge clk) begin
        if (pend_im) begin
            if (q_im.size() == 0) chk("im_unexpected", o_im_rdata, 'x);
            else chk("im_rdata", o_im_rdata, q_im.pop_front());
        end
        if (pend_dm) begin
            if (q_dm.size() == 0) chk("dm_unexpected", o_dm_rdata, 'x);
            else chk("dm_rdata", o_dm_rdata, q_dm.pop_front());
        end
        if (o_sync_done) begin
            if (q_done.size() == 0) chk("sync_done_unexpected", 32'd1, 32'd0);
            else chk("sync_done_cycle", cyc, q_done.pop_front());
        end
        pend_im = !i_rst && i_im_ren && o_ready;
        pend_dm = !i_rst && i_dm_ren && o_ready;
    end

    task automatic clear_inputs();
        i_im_ren   = 1'b0;
        i_im_addr  = '0;
        i_dm_ren   = 1'b0;
        i_dm_wen   = 1'b0;
        i_dm_ben   = '0;
        i_dm_addr  = '0;
        i_dm_wdata = '0;
        i_fence_i  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < 64) begin
            step();
            n++;
        end
        if (!o_ready) chk("ready_timeout", {31'd0, o_ready}, 32'd1);
    endtask

    task automatic dm_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [3:0] b);
        wait_ready();
        i_dm_wen = 1'b1; i_dm_addr = a; i_dm_wdata = d; i_dm_ben = b;
        step();
        clear_inputs();
    endtask

    task automatic dm_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        wait_ready();
        q_dm.push_back(e);
        i_dm_ren = 1'b1; i_dm_addr = a;
        step();
        clear_inputs();
    endtask

    task automatic im_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        wait_ready();
        q_im.push_back(e);
        i_im_ren = 1'b1; i_im_addr = a;
        step();
        clear_inputs();
    endtask

    task automatic fence_sync(input int n);
        wait_ready();
        q_done.push_back(cyc + ((n == 0) ? 1 : n + 2));
        i_fence_i = 1'b1;
        step();
        clear_inputs();
        wait_ready();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        i_rst = 1'b1;
        repeat (3) step();
        i_rst = 1'b0;
        chk("reset_ready", {31'd0, o_ready}, 32'd1);
        chk("reset_syncing", {31'd0, o_syncing}, 32'd0);
        chk("reset_done", {31'd0, o_sync_done}, 32'd0);
        chk("reset_count", 32'(o_log_count), 32'd0);
        chk("reset_im_rdata", o_im_rdata, 32'd0);
        chk("reset_dm_rdata", o_dm_rdata, 32'd0);

        // Basic write, fence, fetch
        dm_write(6'h10, 32'hDEADBEEF, 4'b1111);
        chk("t1_count", 32'(o_log_count), 32'd1);
        fence_sync(1);
        chk("t1_count_clr", 32'(o_log_count), 32'd0);
        im_read(6'h10, 32'hDEADBEEF);
        dm_read(6'h10, 32'hDEADBEEF);

        // Consecutive-duplicate suppression
        dm_write(6'h05, 32'h0505A5A5, 4'b1111);
        dm_write(6'h05, 32'h0505B5B5, 4'b1111);
        chk("t2_count_dup", 32'(o_log_count), 32'd1);
        dm_write(6'h06, 32'h0606C6C6, 4'b1111);
        dm_write(6'h05, 32'h0505D5D5, 4'b1111);
        chk("t2_count", 32'(o_log_count), 32'd3);
        fence_sync(3);
        im_read(6'h05, 32'h0505D5D5);
        im_read(6'h06, 32'h0606C6C6);

        // Byte-enable merge and ben=0 logging
        dm_write(6'h20, 32'h11223344, 4'b1111);
        dm_write(6'h20, 32'h000000AA, 4'b0001);
        dm_read(6'h20, 32'h112233AA);
        dm_write(6'h10, 32'hFFFFFFFF, 4'b0000);
        chk("t3_count", 32'(o_log_count), 32'd2);
        dm_read(6'h10, 32'hDEADBEEF);
        fence_sync(2);
        im_read(6'h20, 32'h112233AA);
        im_read(6'h10, 32'hDEADBEEF);

        // Same-cycle read+write returns old data
        dm_write(6'h30, 32'h12345678, 4'b1111);
        wait_ready();
        q_dm.push_back(32'h12345678);
        i_dm_ren = 1'b1; i_dm_wen = 1'b1; i_dm_addr = 6'h30;
        i_dm_wdata = 32'h9ABCDEF0; i_dm_ben = 4'b1111;
        step();
        clear_inputs();
        dm_read(6'h30, 32'h9ABCDEF0);
        fence_sync(1);
        im_read(6'h30, 32'h9ABCDEF0);

        // Full log triggers auto-sync
        dm_write(6'h01, 32'h11111111, 4'b1111);
        dm_write(6'h02, 32'h22222222, 4'b1111);
        dm_write(6'h03, 32'h33333333, 4'b1111);
        wait_ready();
        q_done.push_back(cyc + 6);
        i_dm_wen = 1'b1; i_dm_addr = 6'h04; i_dm_wdata = 32'h44444444; i_dm_ben = 4'b1111;
        step();
        clear_inputs();
        chk("t4_ready_low", {31'd0, o_ready}, 32'd0);
        chk("t4_count_full", 32'(o_log_count), 32'd4);
        chk("t4_syncing", {31'd0, o_syncing}, 32'd1);
        wait_ready();
        chk("t4_count_clr", 32'(o_log_count), 32'd0);
        chk("t4_dm_hold", o_dm_rdata, 32'h9ABCDEF0);
        chk("t4_im_hold", o_im_rdata, 32'h9ABCDEF0);
        im_read(6'h01, 32'h11111111);
        im_read(6'h02, 32'h22222222);
        im_read(6'h03, 32'h33333333);
        im_read(6'h04, 32'h44444444);

        // Empty-log fence
        wait_ready();
        q_done.push_back(cyc + 1);
        i_fence_i = 1'b1;
        step();
        clear_inputs();
        chk("t5_ready_low", {31'd0, o_ready}, 32'd0);
        step();
        chk("t5_ready_back", {31'd0, o_ready}, 32'd1);
        im_read(6'h10, 32'hDEADBEEF);

        // Reset during sync aborts without a done pulse
        dm_write(6'h07, 32'h07070707, 4'b1111);
        dm_write(6'h08, 32'h08080808, 4'b1111);
        wait_ready();
        i_fence_i = 1'b1;
        step();
        clear_inputs();
        chk("t6_syncing", {31'd0, o_syncing}, 32'd1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("t6_ready", {31'd0, o_ready}, 32'd1);
        chk("t6_count", 32'(o_log_count), 32'd0);
        chk("t6_syncing_clr", {31'd0, o_syncing}, 32'd0);
        repeat (6) step();

        chk("q_im_drained", 32'(q_im.size()), 32'd0);
        chk("q_dm_drained", 32'(q_dm.size()), 32'd0);
        chk("q_done_drained", 32'(q_done.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
